// File: rtl/afifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion and
// the full-compare. Functions work on zero-extended 32-bit values, so any pointer width fits.
package afifo_pkg;

    localparam int FN_W = 32;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray);
        logic [FN_W-1:0] bin;
        bin[FN_W-1] = gray[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Full when the next write pointer equals the read pointer with its two MSBs inverted.
    function automatic logic ptr_full(input logic [FN_W-1:0] wgray_next,
                                      input logic [FN_W-1:0] rgray,
                                      input int unsigned     ptr_w);
        logic [FN_W-1:0] mask;
        mask = FN_W'(2'b11) << (ptr_w - 2);
        return wgray_next == (rgray ^ mask);
    endfunction

endpackage

// File: rtl/afifo_gray_ptr.sv
// Binary/Gray pointer pair with increment enable; the Gray copy is its own flop
// loaded from the next binary value, so it is glitch-free for a synchronizer.
module afifo_gray_ptr
    import afifo_pkg::*;
#(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_inc,
    output logic [PTR_W-2:0] o_addr,
    output logic [PTR_W-1:0] o_gray,
    output logic [PTR_W-1:0] o_gray_next
);

    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_gray;
    logic [PTR_W-1:0] w_bin_next;

    assign w_bin_next  = r_bin + PTR_W'(i_inc);
    assign o_gray_next = PTR_W'(bin2gray(32'(w_bin_next)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= o_gray_next;
        end
    end

    assign o_addr = r_bin[PTR_W-2:0];
    assign o_gray = r_gray;

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-side control of the async FIFO: write pointer, memory strobe, full/overflow.
// Define AFIFO_WR_LEVEL_EN to add the wr_level / wr_almost_full outputs.
module afifo_wr_ctrl
    import afifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
`ifdef AFIFO_WR_LEVEL_EN
    ,
    parameter int ALMOST_FULL_THRESH = 2
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  wr_overflow,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync
`ifdef AFIFO_WR_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_almost_full
`endif
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    generate
        if (ADDR_WIDTH < 2) begin : g_bad_width
            $error("afifo_wr_ctrl: ADDR_WIDTH must be at least 2");
        end
    endgenerate

    logic             w_accept;
    logic             w_full_next;
    logic [PTR_W-1:0] w_gray_next;
    logic             r_full;
    logic             r_overflow;

    // Gating with reset_n drops a write that is in flight while reset is held.
    assign w_accept = wr_en & ~r_full & reset_n;

    afifo_gray_ptr #(
        .PTR_W (PTR_W)
    ) u_wptr (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_inc       (w_accept),
        .o_addr      (mem_waddr),
        .o_gray      (wptr_gray),
        .o_gray_next (w_gray_next)
    );

    assign w_full_next = ptr_full(32'(w_gray_next), 32'(rptr_gray_sync), PTR_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_full     <= w_full_next;
            r_overflow <= r_overflow | (wr_en & r_full);
        end
    end

    assign mem_we      = w_accept;
    assign wr_full     = r_full;
    assign wr_overflow = r_overflow;

`ifdef AFIFO_WR_LEVEL_EN
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [PTR_W-1:0] w_level_next;
    logic [31:0]      w_level_ext;
    logic             w_almost_full_next;
    logic [PTR_W-1:0] r_level;
    logic             r_almost_full;

    // Stale read pointer makes the level an over-estimate, never an under-estimate.
    assign w_level_next = PTR_W'(gray2bin(32'(w_gray_next)) - gray2bin(32'(rptr_gray_sync)));
    assign w_level_ext  = 32'(w_level_next);
    assign w_almost_full_next = (32'(DEPTH) - w_level_ext) <= 32'(ALMOST_FULL_THRESH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_level       <= w_level_next;
            r_almost_full <= w_almost_full_next;
        end
    end

    assign wr_level       = r_level;
    assign wr_almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Self-checking bench for afifo_wr_ctrl (ADDR_WIDTH=2): directed table, wrap,
// randomized traffic against an occupancy-count model, and async reset mid-burst.
module tb_afifo_wr_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int PW    = AW + 1;
`ifdef AFIFO_WR_LEVEL_EN
    localparam int THRESH = 1;
`endif

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic          wr_full;
    logic          wr_overflow;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [PW-1:0] wptr_gray;
    logic [PW-1:0] rptr_gray_sync;
`ifdef AFIFO_WR_LEVEL_EN
    logic [PW-1:0] wr_level;
    logic          wr_almost_full;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int n_txn   = 0;

    // Model: counts of writes accepted and reads seen by the write side.
    int            m_wcnt;
    int            m_rcnt;
    bit            m_full;
    bit            m_ovf;
    logic [PW-1:0] prev_gray;

    typedef struct {
        bit we;
        int rc;
        bit e_we;
        int e_addr;
        int e_gray;
        bit e_full;
        bit e_ovf;
        int e_lvl;
        bit e_af;
    } vec_t;

    vec_t vec[9];

    afifo_wr_ctrl #(
        .ADDR_WIDTH (AW)
`ifdef AFIFO_WR_LEVEL_EN
        ,
        .ALMOST_FULL_THRESH (THRESH)
`endif
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_overflow    (wr_overflow),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .wptr_gray      (wptr_gray),
        .rptr_gray_sync (rptr_gray_sync)
`ifdef AFIFO_WR_LEVEL_EN
        ,
        .wr_level       (wr_level),
        .wr_almost_full (wr_almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    function automatic logic [PW-1:0] gray_of(input int count);
        int b;
        b = count % (2 * DEPTH);
        return PW'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_wcnt    = 0;
        m_rcnt    = 0;
        m_full    = 1'b0;
        m_ovf     = 1'b0;
        prev_gray = '0;
    endtask

    // One clock of traffic, starting and ending at a negedge; rc is the read count.
    task automatic step(input bit we, input int rc);
        bit exp_acc;
        wr_en          = we;
        m_rcnt         = rc;
        rptr_gray_sync = gray_of(rc);
        #1;
        exp_acc = we && !m_full;
        chk("mem_we", 32'(mem_we), 32'(exp_acc));
        chk("mem_waddr", 32'(mem_waddr), 32'(m_wcnt % DEPTH));
        @(posedge clk);
        if (exp_acc) m_wcnt++;
        if (we && m_full) m_ovf = 1'b1;
        m_full = (m_wcnt - m_rcnt) == DEPTH;
        #1;
        chk("wr_full", 32'(wr_full), 32'(m_full));
        chk("wptr_gray", 32'(wptr_gray), 32'(gray_of(m_wcnt)));
        chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
        if (exp_acc) chk("gray_one_bit", 32'($countones(wptr_gray ^ prev_gray)), 32'd1);
`ifdef AFIFO_WR_LEVEL_EN
        chk("wr_level", 32'(wr_level), 32'(m_wcnt - m_rcnt));
        chk("wr_almost_full", 32'(wr_almost_full), 32'((DEPTH - (m_wcnt - m_rcnt)) <= THRESH));
`endif
        prev_gray = wptr_gray;
        n_txn++;
        $display("txn %0d we=%0b rc=%0d acc=%0b gray=%0d full=%0b ovf=%0b",
                 n_txn, we, rc, exp_acc, wptr_gray, wr_full, wr_overflow);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        wr_en          = 1'b0;
        rptr_gray_sync = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_full"}, 32'(wr_full), 32'd0);
        chk({tag, "_ovf"}, 32'(wr_overflow), 32'd0);
        chk({tag, "_gray"}, 32'(wptr_gray), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_waddr), 32'd0);
`ifdef AFIFO_WR_LEVEL_EN
        chk({tag, "_level"}, 32'(wr_level), 32'd0);
        chk({tag, "_af"}, 32'(wr_almost_full), 32'd0);
`endif
    endtask

    initial begin
        //        we rc we addr gray full ovf lvl af
        vec[0] = '{1, 0, 1, 0, 1, 0, 0, 1, 0};
        vec[1] = '{1, 0, 1, 1, 3, 0, 0, 2, 0};
        vec[2] = '{1, 0, 1, 2, 2, 0, 0, 3, 1};
        vec[3] = '{1, 0, 1, 3, 6, 1, 0, 4, 1};
        vec[4] = '{1, 0, 0, 0, 6, 1, 1, 4, 1};
        vec[5] = '{1, 0, 0, 0, 6, 1, 1, 4, 1};
        vec[6] = '{0, 0, 0, 0, 6, 1, 1, 4, 1};
        vec[7] = '{0, 1, 0, 0, 6, 0, 1, 3, 1};
        vec[8] = '{1, 1, 1, 0, 7, 1, 1, 4, 1};

        reset_n        = 1'b0;
        wr_en          = 1'b0;
        rptr_gray_sync = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Fill, overflow, single read release and refill.
        for (int i = 0; i < 9; i++) begin
            wr_en          = vec[i].we;
            rptr_gray_sync = gray_of(vec[i].rc);
            #1;
            chk("tbl_mem_we", 32'(mem_we), 32'(vec[i].e_we));
            chk("tbl_mem_waddr", 32'(mem_waddr), 32'(vec[i].e_addr));
            @(posedge clk);
            #1;
            chk("tbl_wptr_gray", 32'(wptr_gray), 32'(vec[i].e_gray));
            chk("tbl_wr_full", 32'(wr_full), 32'(vec[i].e_full));
            chk("tbl_wr_overflow", 32'(wr_overflow), 32'(vec[i].e_ovf));
`ifdef AFIFO_WR_LEVEL_EN
            chk("tbl_wr_level", 32'(wr_level), 32'(vec[i].e_lvl));
            chk("tbl_wr_almost_full", 32'(wr_almost_full), 32'(vec[i].e_af));
`endif
            $display("vec %0d we=%0b rc=%0d gray=%0d full=%0b ovf=%0b",
                     i, vec[i].we, vec[i].rc, wptr_gray, wr_full, wr_overflow);
            @(negedge clk);
        end

        // Wrap: reader keeps pace, pointer wraps several times with no false full.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, m_wcnt);

        // Random traffic; reads never overtake accepted writes.
        for (int i = 0; i < 150; i++) begin
            bit we;
            int rc;
            we = ($urandom_range(0, 3) != 0);
            rc = m_rcnt;
            if ($urandom_range(0, 2) == 0)
                rc = m_rcnt + int'($urandom_range(0, m_wcnt - m_rcnt));
            step(we, rc);
        end

        // Fill to overflow, then reset asynchronously mid-cycle with wr_en high.
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, m_rcnt);
        wr_en = 1'b1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        rptr_gray_sync = '0;
        step(1'b1, 0);
        step(1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
